// File: rtl/afe2256_lvds_align_ctrl.sv
// AFE2256 LVDS link-training sequencer.
// Enables the AFE training pattern and waits for every channel to lock.
// It then walks the channels in order, issuing bitslips until each channel
// captures the training word. After that it reports per-channel status and
// link_ready, and retrains on its own if any channel loses lock.
module afe2256_lvds_align_ctrl #(
    parameter int          NUM_CHANNELS  = 14,
    parameter logic [11:0] TRAIN_PATTERN = 12'hFC0,
    parameter int          MAX_SLIPS     = 12,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          MATCH_COUNT   = 8,
    parameter int          LOCK_TIMEOUT  = 65535
) (
    input  logic                         clk_sys,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_CHANNELS-1:0]      ch_locked,
    input  logic [NUM_CHANNELS-1:0]      ch_aligned,
    input  logic [NUM_CHANNELS-1:0][11:0] align_vector,
    output logic                         train_en,
    output logic [NUM_CHANNELS-1:0]      bitslip,
    output logic [NUM_CHANNELS-1:0]      ch_trained,
    output logic [NUM_CHANNELS-1:0]      ch_failed,
    output logic                         link_ready,
    output logic                         busy,
    output logic [3:0]                   cur_channel,
    output logic [7:0]                   retrain_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_SETTLE    = 3'd2;
    localparam logic [2:0] S_CHECK     = 3'd3;
    localparam logic [2:0] S_SLIP      = 3'd4;
    localparam logic [2:0] S_NEXT      = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_FAIL      = 3'd7;

    localparam int SW   = (MAX_SLIPS < 1) ? 1 : $clog2(MAX_SLIPS + 1);
    localparam int MW   = (MATCH_COUNT < 1) ? 1 : $clog2(MATCH_COUNT + 1);
    localparam int TMAX = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    logic [2:0]              state_q,   state_d;
    logic [3:0]              idx_q,     idx_d;
    logic [SW-1:0]           slip_q,    slip_d;
    logic [MW-1:0]           match_q,   match_d;
    logic [TW-1:0]           timer_q,   timer_d;
    logic                    train_en_q, train_en_d;
    logic [NUM_CHANNELS-1:0] bitslip_q, bitslip_d;
    logic [NUM_CHANNELS-1:0] trained_q, trained_d;
    logic [NUM_CHANNELS-1:0] failed_q,  failed_d;
    logic                    link_q,    link_d;
    logic                    busy_q,    busy_d;
    logic [3:0]              cur_q,     cur_d;
    logic [7:0]              retrain_q, retrain_d;

    logic all_locked;
    logic cur_match;
    logic begin_train;
    logic lock_lost;

    assign all_locked = &ch_locked;
    assign cur_match  = (align_vector[idx_q] == TRAIN_PATTERN) && ch_aligned[idx_q];

    // Next-state and next-output decode for the training sequencer
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        slip_d      = slip_q;
        match_d     = match_q;
        timer_d     = timer_q;
        train_en_d  = train_en_q;
        bitslip_d   = '0;
        trained_d   = trained_q;
        failed_d    = failed_q;
        link_d      = link_q;
        busy_d      = busy_q;
        retrain_d   = retrain_q;
        begin_train = 1'b0;
        lock_lost   = 1'b0;

        case (state_q)
            S_IDLE, S_FAIL: begin
                if (start) begin
                    begin_train = 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (all_locked) begin
                    state_d = S_SETTLE;
                    timer_d = '0;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    failed_d   = ~ch_locked;
                    state_d    = S_FAIL;
                    busy_d     = 1'b0;
                    train_en_d = 1'b0;
                    link_d     = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_SETTLE: begin
                if (!all_locked) begin
                    lock_lost = 1'b1;
                end else if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_CHECK;
                    match_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CHECK: begin
                if (!all_locked) begin
                    lock_lost = 1'b1;
                end else if (cur_match) begin
                    if (match_q == MW'(MATCH_COUNT - 1)) begin
                        trained_d[idx_q] = 1'b1;
                        state_d          = S_NEXT;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end else if (slip_q >= SW'(MAX_SLIPS)) begin
                    failed_d[idx_q] = 1'b1;
                    state_d         = S_NEXT;
                end else begin
                    bitslip_d[idx_q] = 1'b1;
                    state_d          = S_SLIP;
                end
            end
            S_SLIP: begin
                if (!all_locked) begin
                    lock_lost = 1'b1;
                end else begin
                    slip_d  = slip_q + SW'(1);
                    timer_d = '0;
                    state_d = S_SETTLE;
                end
            end
            S_NEXT: begin
                if (idx_q == 4'(NUM_CHANNELS - 1)) begin
                    busy_d     = 1'b0;
                    train_en_d = 1'b0;
                    if (|failed_q) begin
                        state_d = S_FAIL;
                        link_d  = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        link_d  = 1'b1;
                    end
                end else begin
                    idx_d   = idx_q + 4'd1;
                    slip_d  = '0;
                    timer_d = '0;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                if (!all_locked) begin
                    begin_train = 1'b1;
                    if (retrain_q != 8'hFF) begin
                        retrain_d = retrain_q + 8'd1;
                    end
                end else if (start) begin
                    begin_train = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (begin_train) begin
            state_d    = S_WAIT_LOCK;
            idx_d      = '0;
            slip_d     = '0;
            match_d    = '0;
            timer_d    = '0;
            trained_d  = '0;
            failed_d   = '0;
            busy_d     = 1'b1;
            train_en_d = 1'b1;
            link_d     = 1'b0;
        end

        if (lock_lost) begin
            state_d   = S_WAIT_LOCK;
            idx_d     = '0;
            slip_d    = '0;
            match_d   = '0;
            timer_d   = '0;
            trained_d = '0;
            bitslip_d = '0;
        end

        cur_d = busy_d ? idx_d : cur_q;
    end

    // State and registered outputs, cleared asynchronously by rst
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            slip_q     <= '0;
            match_q    <= '0;
            timer_q    <= '0;
            train_en_q <= 1'b0;
            bitslip_q  <= '0;
            trained_q  <= '0;
            failed_q   <= '0;
            link_q     <= 1'b0;
            busy_q     <= 1'b0;
            cur_q      <= '0;
            retrain_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            slip_q     <= slip_d;
            match_q    <= match_d;
            timer_q    <= timer_d;
            train_en_q <= train_en_d;
            bitslip_q  <= bitslip_d;
            trained_q  <= trained_d;
            failed_q   <= failed_d;
            link_q     <= link_d;
            busy_q     <= busy_d;
            cur_q      <= cur_d;
            retrain_q  <= retrain_d;
        end
    end

    assign train_en      = train_en_q;
    assign bitslip       = bitslip_q;
    assign ch_trained    = trained_q;
    assign ch_failed     = failed_q;
    assign link_ready    = link_q;
    assign busy          = busy_q;
    assign cur_channel   = cur_q;
    assign retrain_count = retrain_q;

endmodule
